// File: rtl/spike_trap_pkg.sv
// Shared types and the trap rule table for the spike trap scheduler.
// Rule 0 has the highest priority when several rules are ready together.
package spike_trap_pkg;

    localparam int NUM_RULES  = 8;
    localparam int NUM_SPIKES = 24;
    localparam int DELAY_W    = 4;
    localparam int IDX_W      = $clog2(NUM_RULES);
    localparam int SPIKE_W    = $clog2(NUM_SPIKES);

    typedef struct packed {
        logic [9:0]         x_lo;
        logic [9:0]         x_hi;
        logic [9:0]         y_max;
        logic [SPIKE_W-1:0] spike_a;
        logic [SPIKE_W-1:0] spike_b;
        logic               has_b;
        logic               dir_up;
        logic [DELAY_W-1:0] delay;
    } rule_t;

    typedef rule_t [NUM_RULES-1:0] rule_tab_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE_A,
        ISSUE_B
    } sched_state_t;

    function automatic rule_t mk_rule(
        input logic [9:0]         xl,
        input logic [9:0]         xh,
        input logic [9:0]         ym,
        input logic [SPIKE_W-1:0] sa,
        input logic [SPIKE_W-1:0] sb,
        input logic               hb,
        input logic               up,
        input logic [DELAY_W-1:0] d
    );
        rule_t r;
        r.x_lo    = xl;
        r.x_hi    = xh;
        r.y_max   = ym;
        r.spike_a = sa;
        r.spike_b = sb;
        r.has_b   = hb;
        r.dir_up  = up;
        r.delay   = d;
        return r;
    endfunction

    function automatic rule_tab_t default_rules();
        rule_tab_t t;
        t[0] = mk_rule(10'd210, 10'd211, 10'h3FF, 5'd15, 5'd0,  1'b0, 1'b0, 4'd0);
        t[1] = mk_rule(10'd290, 10'd291, 10'h3FF, 5'd16, 5'd0,  1'b0, 1'b0, 4'd0);
        t[2] = mk_rule(10'd307, 10'd308, 10'h3FF, 5'd18, 5'd0,  1'b0, 1'b0, 4'd0);
        t[3] = mk_rule(10'd368, 10'd369, 10'd270, 5'd7,  5'd0,  1'b0, 1'b1, 4'd0);
        t[4] = mk_rule(10'd285, 10'd286, 10'd270, 5'd6,  5'd0,  1'b0, 1'b1, 4'd0);
        t[5] = mk_rule(10'd220, 10'd221, 10'd270, 5'd4,  5'd20, 1'b1, 1'b1, 4'd0);
        t[6] = mk_rule(10'd405, 10'd406, 10'h3FF, 5'd21, 5'd22, 1'b1, 1'b0, 4'd2);
        t[7] = mk_rule(10'd0,   10'd0,   10'd0,   5'd0,  5'd0,  1'b0, 1'b0, 4'd0);
        return t;
    endfunction

    localparam rule_tab_t RULES = default_rules();

    function automatic logic [IDX_W-1:0] first_set(input logic [NUM_RULES-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--)
            if (v[i]) idx = IDX_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/trap_rule_timer.sv
// One trigger rule: fires once per Reset, then counts its delay down.
// Ready stays high until the scheduler takes the rule via clear_pending.
module trap_rule_timer
    import spike_trap_pkg::*;
(
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               hit,
    input  logic               dead,
    input  logic               clear_pending,
    input  logic [DELAY_W-1:0] delay,
    output logic               fired,
    output logic               pending,
    output logic               ready
);

    logic [DELAY_W-1:0] cnt;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            fired   <= 1'b0;
            pending <= 1'b0;
            cnt     <= '0;
        end else if (hit && !fired && !dead) begin
            fired   <= 1'b1;
            pending <= 1'b1;
            cnt     <= delay;
        end else begin
            if (clear_pending)
                pending <= 1'b0;
            if (pending && cnt != '0 && !dead)
                cnt <= cnt - DELAY_W'(1);
        end
    end

    assign ready = pending && (cnt == '0);

endmodule

// File: rtl/spike_trap_scheduler.sv
// Arms trap rules from player position and issues their spike launches
// to the updater one command at a time over valid/ready.
module spike_trap_scheduler
    import spike_trap_pkg::*;
#(
    parameter rule_tab_t RULE_TAB = RULES
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [9:0]           ManX,
    input  logic [9:0]           ManY,
    input  logic                 Dead,
    output logic                 launch_valid,
    input  logic                 launch_ready,
    output logic [SPIKE_W-1:0]   launch_spike,
    output logic                 launch_up,
    output logic [NUM_RULES-1:0] fired_mask,
    output logic                 busy
);

    logic [NUM_RULES-1:0] zone;
    logic [NUM_RULES-1:0] pend;
    logic [NUM_RULES-1:0] rdy;
    logic [NUM_RULES-1:0] clr;
    logic [IDX_W-1:0]     sel;
    logic                 capture;

    sched_state_t       state;
    sched_state_t       nxt;
    logic [SPIKE_W-1:0] lat_b;
    logic               lat_has_b;
    logic               valid_d;
    logic [SPIKE_W-1:0] spike_d;
    logic               up_d;

    for (genvar r = 0; r < NUM_RULES; r++) begin : g_rule
        assign zone[r] = (ManX >= RULE_TAB[r].x_lo) &&
                         (ManX <= RULE_TAB[r].x_hi) &&
                         (ManY <= RULE_TAB[r].y_max);

        trap_rule_timer u_timer (
            .frame_clk     (frame_clk),
            .Reset         (Reset),
            .hit           (zone[r]),
            .dead          (Dead),
            .clear_pending (clr[r]),
            .delay         (RULE_TAB[r].delay),
            .fired         (fired_mask[r]),
            .pending       (pend[r]),
            .ready         (rdy[r])
        );
    end

    assign sel  = first_set(rdy);
    assign clr  = capture ? (NUM_RULES'(1) << sel) : '0;
    assign busy = (|pend) || (state != IDLE);

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state        <= IDLE;
            lat_b        <= '0;
            lat_has_b    <= 1'b0;
            launch_valid <= 1'b0;
            launch_spike <= '0;
            launch_up    <= 1'b0;
        end else begin
            state        <= nxt;
            launch_valid <= valid_d;
            launch_spike <= spike_d;
            launch_up    <= up_d;
            if (capture) begin
                lat_b     <= RULE_TAB[sel].spike_b;
                lat_has_b <= RULE_TAB[sel].has_b;
            end
        end
    end

    always_comb begin
        nxt     = state;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (!Dead && (|rdy)) begin
                    nxt     = ISSUE_A;
                    capture = 1'b1;
                end
            end
            ISSUE_A: begin
                if (launch_ready)
                    nxt = lat_has_b ? ISSUE_B : IDLE;
            end
            ISSUE_B: begin
                if (launch_ready)
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Payload only changes on capture or A->B; otherwise it holds.
    always_comb begin
        valid_d = (nxt != IDLE);
        spike_d = launch_spike;
        up_d    = launch_up;
        if (capture) begin
            spike_d = RULE_TAB[sel].spike_a;
            up_d    = RULE_TAB[sel].dir_up;
        end else if (state == ISSUE_A && nxt == ISSUE_B) begin
            spike_d = lat_b;
        end
    end

endmodule
